// File: rtl/inst_fetch_unit_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage.
package inst_fetch_unit_pkg;

    localparam int unsigned DWL_DEF  = 32;
    localparam int unsigned AWL_DEF  = 5;
    localparam int unsigned PC_W_DEF = 32;

    localparam logic [PC_W_DEF-1:0] RESET_PC_DEF = '0;

    // addi x0, x0, 0
    localparam logic [DWL_DEF-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [PC_W_DEF-1:0] pc;
        logic [DWL_DEF-1:0]  inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_fetch_buf.sv
// fetch_buf: 2-deep synchronous FIFO with flush; head reads as zero when empty.
module fetch_buf #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wptr;
    logic         rptr;

    // When full, push and pop together overwrite the slot being read out,
    // which becomes the new tail after rptr advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            count <= '0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = (count != 2'd0) ? mem[rptr] : '0;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: PC, instruction-memory address, 2-entry fetch buffer.
// Optional macro FETCH_PERF_CNT_EN adds FETCH_CNT / STALL_CNT counters.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int unsigned      DWL      = DWL_DEF,
    parameter int unsigned      AWL      = AWL_DEF,
    parameter int unsigned      PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0]  RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic            CLK,
    input  logic            RST_N,
    output logic [AWL-1:0]  IMA,
    input  logic [DWL-1:0]  IMRD,
    input  logic            BR_EN,
    input  logic [PC_W-1:0] BR_TGT,
    output logic            ID_VALID,
    input  logic            ID_READY,
    output logic [DWL-1:0]  ID_INST,
    output logic [PC_W-1:0] ID_PC
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     FETCH_CNT,
    output logic [31:0]     STALL_CNT
`endif
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [DWL-1:0]  inst;
    } entry_t;

    logic [PC_W-1:0] pc;
    logic [1:0]      count;
    logic            deq;
    logic            push;
    entry_t          wr_entry;
    entry_t          head;
    logic            unused_tgt_bits;

    assign unused_tgt_bits = ^BR_TGT[1:0];

    assign IMA      = pc[AWL+1:2];
    assign ID_VALID = (count != 2'd0);
    assign deq      = ID_VALID & ID_READY;
    assign push     = !BR_EN & ((count != 2'd2) | deq);

    assign wr_entry = '{pc: pc, inst: IMRD};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc <= RESET_PC;
        end else if (BR_EN) begin
            pc <= {BR_TGT[PC_W-1:2], 2'b00};
        end else if (push) begin
            pc <= pc + PC_W'(4);
        end
    end

    fetch_buf #(
        .W ($bits(entry_t))
    ) u_fetch_buf (
        .clk   (CLK),
        .rst_n (RST_N),
        .flush (BR_EN),
        .push  (push),
        .pop   (deq & !BR_EN),
        .wdata (wr_entry),
        .rdata (head),
        .count (count)
    );

    assign ID_INST = head.inst;
    assign ID_PC   = head.pc;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            FETCH_CNT <= '0;
            STALL_CNT <= '0;
        end else begin
            if (push) begin
                FETCH_CNT <= FETCH_CNT + 32'd1;
            end
            if (!push && !BR_EN) begin
                STALL_CNT <= STALL_CNT + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction-fetch stage of the 5-stage pipeline and the initiator side of the instruction-memory read port. It owns the program counter and drives the word address to instruction memory, which answers combinationally in the same cycle. Each returned word is captured with its PC into a 2-entry fetch buffer and presented to the decode stage over a valid/ready handshake. Branch/jump redirects from later stages flush the buffer and reload the PC.

## Interface
- DWL, 32, instruction word width; must equal instruction-memory data width
- AWL, 5, instruction-memory word-address width
- PC_W, 32, program-counter width (byte address)
- RESET_PC, 0, PC value loaded on reset; bits [1:0] must be 0

Ports:
- CLK  input  1  pipeline clock, rising edge
- RST_N  input  1  reset, asynchronous, active-low
- IMA  output  AWL  instruction-memory word address = PC[AWL+1:2]
- IMRD  input  DWL  instruction-memory read data, valid the same cycle as IMA
- BR_EN  input  1  redirect request from EX/MEM
- BR_TGT  input  PC_W  redirect target byte address
- ID_VALID  output  1  buffer head holds a valid instruction
- ID_READY  input  1  decode accepts the head this cycle
- ID_INST  output  DWL  instruction at buffer head
- ID_PC  output  PC_W  byte PC of ID_INST

## Operation
- State: PC register, 2-entry buffer of {PC, INST}, 2-bit occupancy count (0..2), read/write pointers.
- IMA always reflects current PC; no read enable, memory is always read.
- deq = ID_VALID & ID_READY.
- push = !BR_EN & (count < 2 | deq). On push: write {PC, IMRD} at tail, PC <= PC + 4.
- No push -> PC holds (stall). IMRD ignored.
- BR_EN = 1: count <= 0, pointers reset, PC <= {BR_TGT[PC_W-1:2], 2'b00}; no push that cycle; redirect wins over any simultaneous deq or push. A deq in the same cycle still counts as consumed by decode.
- Misaligned BR_TGT: bits [1:0] discarded silently.
- Simultaneous push and deq at count 2: count stays 2, order preserved.
- ID_VALID = (count != 0). ID_INST / ID_PC = head entry; both drive 0 when count = 0.
- PC increments modulo 2^PC_W; IMA wraps modulo 2^AWL with no special handling.
- Decode must not see reordered, duplicated or dropped instructions except those flushed by BR_EN.

## Timing
- Reset (RST_N low, any time including mid-fetch): PC = RESET_PC, count = 0, ID_VALID = 0, ID_INST = 0, ID_PC = 0, IMA = RESET_PC[AWL+1:2]. Effect immediate, not clock-gated.
- First rising CLK edge with RST_N high: entry for RESET_PC pushed; ID_VALID = 1 after that edge.
- Fetch-to-decode latency: 1 cycle (IMA presented in cycle n, instruction at head in cycle n+1 when buffer was empty).
- Throughput: 1 instruction/cycle while ID_READY held high.
- Redirect: BR_EN sampled at edge n; ID_VALID = 0 in cycle n+1; target instruction at head in cycle n+2.
- Buffer absorbs a 1-cycle ID_READY drop without losing the word fetched in that cycle.

## Configuration
- FETCH_PERF_CNT_EN defined: adds outputs FETCH_CNT (32, pushes since reset) and STALL_CNT (32, cycles with !push & !BR_EN); both reset to 0, wrap at 2^32.
- Undefined: ports and counters absent; functional behaviour identical.

## Structure
- Shared pipeline package: DWL/PC_W defaults, RESET_PC constant, fetch-buffer entry typedef {pc, inst}, NOP encoding.
- One sub-module: fetch_buf — 2-deep synchronous FIFO with flush, parameterized on entry width; PC logic stays in the top.

## Test plan
- Reset then ID_READY = 1 with memory word k = 0x1000_0000 + k -> ID_PC 0, 4, 8, … and ID_INST 0x1000_0000, 0x1000_0001, … on consecutive cycles after first edge.
- Hold ID_READY = 0 for 5 cycles -> count saturates at 2, PC stops at 8, IMA = 2; on release instructions 0, 1, 2 appear in order with no gap or duplicate.
- BR_EN with BR_TGT = 0x40 while buffer full and deq active -> next cycle ID_VALID = 0, following cycle ID_PC = 0x40, ID_INST = word 16.
- BR_TGT = 0x43 -> PC loads 0x40, IMA = 16.
- PC at 0x7C with AWL = 5 -> next IMA = 0 (wrap), ID_PC = 0x80.
- Assert RST_N low mid-stream with count = 2 -> ID_VALID, ID_INST, ID_PC drop to 0 immediately; fetch restarts at RESET_PC; with FETCH_PERF_CNT_EN, FETCH_CNT and STALL_CNT read 0.
